// File: rtl/multi_channel_gate_counter.sv
// multi_channel_gate_counter
//   Counts rising edges on CHANNELS pulse inputs while GATE is high. When GATE
//   falls, the counts are frozen into a snapshot bank. The snapshot is then
//   unloaded one word per channel over a valid/ready handshake. A new window
//   that opens while an unload is still in progress is rejected and flagged
//   on DROP.
//
//   Optional feature: define GATE_COUNTER_OVERFLOW_FLAG_EN to add a sticky
//   per-channel overflow bit, presented on OUT_OVF alongside OUT_COUNT.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   GATE       in   counting window (high = count)
//   PMT        in   [CHANNELS] pulse inputs
//   OUT_VALID  out  result word available
//   OUT_READY  in   downstream accepts result word
//   OUT_CHAN   out  channel index of the current word
//   OUT_COUNT  out  [WIDTH] count of channel OUT_CHAN in the last window
//   OUT_LAST   out  current word is the final channel
//   BUSY       out  FSM not idle
//   DROP       out  one-cycle pulse when a window is rejected
//   OUT_OVF    out  (optional) sticky overflow of channel OUT_CHAN
module multi_channel_gate_counter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                GATE,
  input  logic [CHANNELS-1:0] PMT,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [CW-1:0]       OUT_CHAN,
  output logic [WIDTH-1:0]    OUT_COUNT,
  output logic                OUT_LAST,
  output logic                BUSY,
  output logic                DROP
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
  ,
  output logic                OUT_OVF
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [CW-1:0]    IDX_LAST = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, COUNT, UNLOAD} state_t;

  state_t              state, state_nxt;
  logic                gate_p1;
  logic [CHANNELS-1:0] pmt_p1;
  logic [WIDTH-1:0]    cnt  [CHANNELS];
  logic [WIDTH-1:0]    snap [CHANNELS];
  logic [CW-1:0]       idx;
  logic                drop_p1;

  logic                rise, fall, unload, xfer, at_last;
  logic [CHANNELS-1:0] edges;

  function automatic logic [WIDTH-1:0] inc_sat(input logic [WIDTH-1:0] v);
    if (v == CNT_MAX) return SATURATE ? CNT_MAX : '0;
    return v + CNT_ONE;
  endfunction

  assign rise    = GATE & ~gate_p1;
  assign fall    = ~GATE & gate_p1;
  assign edges   = PMT & ~pmt_p1;
  assign unload  = (state == UNLOAD);
  assign at_last = (idx == IDX_LAST);
  assign xfer    = unload & OUT_READY;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = COUNT;
      COUNT:   if (fall) state_nxt = UNLOAD;
      UNLOAD:  if (xfer && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Edge-detect stage: previous-cycle inputs reset high so levels already
  // asserted at reset release do not look like fresh edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gate_p1 <= 1'b1;
      pmt_p1  <= '1;
    end else begin
      gate_p1 <= GATE;
      pmt_p1  <= PMT;
    end
  end

`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
  logic [CHANNELS-1:0] ovf, snap_ovf, at_max;

  always_comb begin
    at_max = '0;
    for (int n = 0; n < CHANNELS; n++) at_max[n] = (cnt[n] == CNT_MAX);
  end
`endif

  // Counter / snapshot stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n < CHANNELS; n++) begin
        cnt[n]  <= '0;
        snap[n] <= '0;
      end
      idx     <= '0;
      drop_p1 <= 1'b0;
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
      ovf      <= '0;
      snap_ovf <= '0;
`endif
    end else begin
      // Any rise seen during unload (including on the final transfer) is lost.
      drop_p1 <= unload & rise;
      case (state)
        IDLE: begin
          if (rise) begin
            // Edges coinciding with the window opening are counted.
            for (int n = 0; n < CHANNELS; n++) cnt[n] <= edges[n] ? CNT_ONE : '0;
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
            ovf <= '0;
`endif
          end
        end
        COUNT: begin
          if (fall) begin
            // Edges in the closing cycle are deliberately not counted.
            for (int n = 0; n < CHANNELS; n++) snap[n] <= cnt[n];
            idx <= '0;
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
            snap_ovf <= ovf;
`endif
          end else begin
            for (int n = 0; n < CHANNELS; n++)
              if (edges[n]) cnt[n] <= inc_sat(cnt[n]);
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
            ovf <= ovf | (edges & at_max);
`endif
          end
        end
        UNLOAD: begin
          // Index returns to 0 after the last word so OUT_CHAN idles at 0.
          if (xfer) idx <= at_last ? '0 : idx + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign OUT_VALID = unload;
  assign OUT_LAST  = unload & at_last;
  assign OUT_CHAN  = idx;
  assign OUT_COUNT = unload ? snap[idx] : '0;
  assign BUSY      = (state != IDLE);
  assign DROP      = drop_p1;
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
  assign OUT_OVF   = unload & snap_ovf[idx];
`endif

endmodule

// File: tb/tb_multi_channel_gate_counter.sv
// Bench for multi_channel_gate_counter. Three instances share one stimulus:
// the default build (WIDTH=8, saturating) plus WIDTH=4 saturating and
// WIDTH=4 wrapping, so overflow behaviour is checked on the same windows.
module tb_multi_channel_gate_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       gate;
  logic [3:0] pmt;
  logic       ready;

  logic       m_valid, m_last, m_busy, m_drop;
  logic [1:0] m_chan;
  logic [7:0] m_count;
  logic       s_valid, s_last, s_busy, s_drop;
  logic [1:0] s_chan;
  logic [3:0] s_count;
  logic       w_valid, w_last, w_busy, w_drop;
  logic [1:0] w_chan;
  logic [3:0] w_count;
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
  logic       m_ovf, s_ovf, w_ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int pc [4];

  always #5 clk = ~clk;

  multi_channel_gate_counter #(.CHANNELS(4), .WIDTH(8), .SATURATE(1'b1)) dut (
    .CLK(clk), .RST(rst), .GATE(gate), .PMT(pmt),
    .OUT_VALID(m_valid), .OUT_READY(ready), .OUT_CHAN(m_chan),
    .OUT_COUNT(m_count), .OUT_LAST(m_last), .BUSY(m_busy), .DROP(m_drop)
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
    , .OUT_OVF(m_ovf)
`endif
  );

  multi_channel_gate_counter #(.CHANNELS(4), .WIDTH(4), .SATURATE(1'b1)) dut_s (
    .CLK(clk), .RST(rst), .GATE(gate), .PMT(pmt),
    .OUT_VALID(s_valid), .OUT_READY(ready), .OUT_CHAN(s_chan),
    .OUT_COUNT(s_count), .OUT_LAST(s_last), .BUSY(s_busy), .DROP(s_drop)
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
    , .OUT_OVF(s_ovf)
`endif
  );

  multi_channel_gate_counter #(.CHANNELS(4), .WIDTH(4), .SATURATE(1'b0)) dut_w (
    .CLK(clk), .RST(rst), .GATE(gate), .PMT(pmt),
    .OUT_VALID(w_valid), .OUT_READY(ready), .OUT_CHAN(w_chan),
    .OUT_COUNT(w_count), .OUT_LAST(w_last), .BUSY(w_busy), .DROP(w_drop)
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
    , .OUT_OVF(w_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One window: GATE high for len cycles, channel n pulses every other cycle
  // starting on the opening cycle until pc[n] pulses are sent, then GATE falls.
  task automatic run_window();
    int mx, len;
    mx = 0;
    for (int n = 0; n < 4; n++) if (pc[n] > mx) mx = pc[n];
    len = (2 * mx + 2 > 20) ? 2 * mx + 2 : 20;
    for (int c = 0; c < len; c++) begin
      gate = 1'b1;
      for (int n = 0; n < 4; n++) pmt[n] = ((c % 2) == 0) && ((c / 2) < pc[n]);
      tick();
      if (c == 0) begin
        chk("count_busy", m_busy, 1);
        chk("count_novalid", m_valid, 0);
      end
    end
    gate = 1'b0;
    pmt  = '0;
    tick();
  endtask

  // Drain the four result words with OUT_READY high. If rise_at >= 0, GATE
  // rises on the cycle word rise_at transfers.
  task automatic collect(input string tag, input int rise_at);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_vld"}, m_valid, 1);
      chk({tag, "_chan"}, m_chan, k);
      chk({tag, "_cnt"}, m_count, pc[k]);
      chk({tag, "_last"}, m_last, (k == 3));
      chk({tag, "_scnt"}, s_count, (pc[k] > 15) ? 15 : pc[k]);
      chk({tag, "_wcnt"}, w_count, pc[k] % 16);
`ifdef GATE_COUNTER_OVERFLOW_FLAG_EN
      chk({tag, "_movf"}, m_ovf, (pc[k] > 255));
      chk({tag, "_sovf"}, s_ovf, (pc[k] > 15));
      chk({tag, "_wovf"}, w_ovf, (pc[k] > 15));
`endif
      ready = 1'b1;
      if (k == rise_at) gate = 1'b1;
      tick();
      if (rise_at >= 0) chk({tag, "_drop"}, m_drop, (k == rise_at));
    end
    ready = 1'b0;
    chk({tag, "_end_vld"}, m_valid, 0);
    chk({tag, "_end_busy"}, m_busy, 0);
    chk({tag, "_end_last"}, m_last, 0);
  endtask

  initial begin
    rst = 1'b1; gate = 1'b0; pmt = '0; ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", m_busy, 0);
    chk("rst_vld", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_drop", m_drop, 0);
    chk("rst_chan", m_chan, 0);
    chk("rst_cnt", m_count, 0);
    rst = 1'b0;
    tick();

    // Basic window, counts 3,0,5,0
    pc = '{3, 0, 5, 0};
    ready = 1'b1;
    run_window();
    collect("basic", -1);
    tick();

    // 20 pulses on channel 1: 20 / 15 saturated / 4 wrapped
    pc = '{0, 20, 0, 0};
    run_window();
    collect("ovf", -1);
    tick();

    // Back-pressure: outputs hold for 10 cycles of OUT_READY low
    pc = '{1, 2, 3, 4};
    run_window();
    for (int i = 0; i < 10; i++) begin
      chk("hold_vld", m_valid, 1);
      chk("hold_chan", m_chan, 0);
      chk("hold_cnt", m_count, 1);
      tick();
    end
    collect("hold", -1);
    tick();

    // GATE rise during unload is dropped; GATE stays high afterwards
    pc = '{0, 0, 0, 2};
    run_window();
    collect("drop_mid", 0);
    repeat (4) tick();
    chk("drop_mid_idle", m_busy, 0);
    chk("drop_mid_novld", m_valid, 0);
    gate = 1'b0;
    tick();

    // GATE rise on the final transfer is dropped too
    pc = '{2, 1, 0, 0};
    run_window();
    collect("drop_last", 3);
    repeat (5) tick();
    chk("drop_last_idle", m_busy, 0);
    chk("drop_last_novld", m_valid, 0);
    gate = 1'b0;
    tick();

    // GATE and PMT high across reset release: no window opens
    gate = 1'b1; pmt = '1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rstrel_busy", m_busy, 0);
    chk("rstrel_vld", m_valid, 0);
    gate = 1'b0; pmt = '0;
    tick();
    chk("rstrel_busy2", m_busy, 0);
    pc = '{2, 0, 0, 0};
    run_window();
    collect("after_rel", -1);
    tick();

    // Reset in the middle of unload discards the pending words
    pc = '{0, 0, 3, 0};
    run_window();
    ready = 1'b1;
    tick();
    chk("midrst_chan1", m_chan, 1);
    ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_vld", m_valid, 0);
    chk("midrst_busy", m_busy, 0);
    chk("midrst_chan", m_chan, 0);
    chk("midrst_cnt", m_count, 0);
    rst = 1'b0;
    tick();
    chk("midrst_vld2", m_valid, 0);
    pc = '{1, 0, 0, 0};
    run_window();
    collect("post_rst", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
